task_dispatcher: RTL and testbench
==================================

TASK_DISPATCHER -- requirements
Module: task_dispatcher

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of cores served (1..32).
REQ-002 SHALL have parameter TM_DEPTH, default 16, task-memory frames (power of 2, >=4); AW = clog2(TM_DEPTH).
REQ-003 SHALL have parameter LOAD_BEATS, default 4, beats per instruction frame (>=1); BW = clog2(LOAD_BEATS), min 1.
REQ-004 SHALL have parameter BUS_W, default 16, instruction beat width; FRAME_W = LOAD_BEATS*BUS_W (must be >= 12+NUM_CORES+AW).
REQ-005 SHALL have a single clock, clk; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 run  input  1  one-cycle start pulse, sampled only in IDLE or HALT.
REQ-009 task_mem  input  TM_DEPTH*FRAME_W  flat task memory; frame i = bits [i*FRAME_W +: FRAME_W].
REQ-010 ready  input  NUM_CORES  per-core idle flag.
REQ-011 start  output  NUM_CORES  per-core load strobe for the current beat.
REQ-012 insn_beat  output  BW  index of current beat.
REQ-013 insn_data  output  BUS_W  beat payload = frame bits [insn_beat*BUS_W +: BUS_W].
REQ-014 vga_en  output  1  one-cycle display request.
REQ-015 vga_end  input  1  display complete, level or pulse.
REQ-016 busy  output  1  high in every state except IDLE and HALT.
REQ-017 done  output  1  high in HALT.
REQ-018 addr_err  output  1  sticky: a NEXT field >= TM_DEPTH was used.

Function
REQ-019 Control frame (CF) fields SHALL be: CNT [7:0] instruction frames following; MASK [8 +: NUM_CORES]; FENCE [8+NUM_CORES +: 2] (00 NO, 01 ACQ, 10 REL, 11 ACQ_REL); STOP [10+NUM_CORES]; LOOP [11+NUM_CORES]; NEXT [12+NUM_CORES +: AW].
REQ-020 States SHALL be IDLE, FETCH, GATE, LOAD, DRAIN, DISP, VWAIT, HALT.
REQ-021 IDLE/HALT + run -> FETCH, ptr=0, addr_err cleared.
REQ-022 FETCH SHALL latch CF at ptr in one cycle, ptr<=ptr+1 (mod TM_DEPTH), -> GATE.
REQ-023 GATE SHALL proceed when (ready & MASK)==MASK for NO/REL, or ready all-ones for ACQ/ACQ_REL; else hold.
REQ-024 GATE exit: CNT>0 -> LOAD, beat=0, frame counter=CNT; CNT==0 -> DRAIN.
REQ-025 LOAD SHALL assert start=MASK for LOAD_BEATS consecutive cycles per frame, insn_beat 0..LOAD_BEATS-1, data from task_mem[ptr]; ready ignored during LOAD.
REQ-026 On last beat: ptr<=ptr+1 mod TM_DEPTH, counter-1; counter reaches 0 -> DRAIN, else next frame immediately (no gap).
REQ-027 DRAIN: if FENCE is REL/ACQ_REL or STOP=1, wait for ready all-ones; then STOP=0 -> FETCH, STOP=1 -> DISP; else -> FETCH next cycle.
REQ-028 DISP SHALL pulse vga_en exactly one cycle -> VWAIT; vga_end sampled from the cycle after vga_en.
REQ-029 VWAIT + vga_end: LOOP=1 -> FETCH, ptr<=NEXT (NEXT>=TM_DEPTH: ptr<=0, addr_err<=1); LOOP=0 -> HALT.
REQ-030 run outside IDLE/HALT SHALL be ignored; MASK=0 yields LOAD cycles with start=0, pointer still advances.
REQ-031 ptr SHALL wrap TM_DEPTH-1 -> 0 in FETCH and LOAD.
REQ-032 start, vga_en SHALL be 0 in every state other than LOAD, DISP respectively.

Reset
REQ-033 Reset asserted at any time SHALL immediately force IDLE, ptr=0, beat=0, start=0, insn_beat=0, vga_en=0, busy=0, done=0, addr_err=0, latched CF=0; aborts any LOAD mid-frame.
REQ-034 After release, the block SHALL stay in IDLE until run.

Verification
REQ-035 NUM_CORES=4, LOAD_BEATS=4: CF0{CNT=2,MASK=0101,NO}, ready=1111, run -> start=0101 for 8 consecutive cycles, insn_beat 0,1,2,3,0,1,2,3, data matches frames 1,2.
REQ-036 CF{FENCE=ACQ,MASK=0001}, ready=0001 -> GATE holds; ready=1111 -> LOAD begins next cycle.
REQ-037 CF{CNT=1,STOP=1,LOOP=1,NEXT=0}, ready=1111 -> one vga_en pulse; vga_end 5 cycles later -> FETCH at ptr 0, busy stays 1.
REQ-038 CF at frame 15, CNT=2, TM_DEPTH=16 -> instruction frames read from 0 and 1, next FETCH at ptr 2.
REQ-039 LOOP=1, NEXT=20 with AW=5/TM_DEPTH=16 impossible; use TM_DEPTH=16, NEXT field forced 4'hF legal and 0 check; plus reset asserted at LOAD beat 2 -> start=0 same cycle, IDLE, done=0.
REQ-040 CF{CNT=0,STOP=1,LOOP=0} -> vga_en, vga_end -> HALT, done=1, busy=0; run -> restarts at ptr 0.

Source files
------------

// File: rtl/task_dispatcher.sv
// Task dispatcher: walks control frames in task memory, streams instruction
// frames to a core group and sequences display requests.
module task_dispatcher #(
    parameter  int NUM_CORES  = 4,
    parameter  int TM_DEPTH   = 16,
    parameter  int LOAD_BEATS = 4,
    parameter  int BUS_W      = 16,
    localparam int AW         = $clog2(TM_DEPTH),
    localparam int BW         = (LOAD_BEATS > 1) ? $clog2(LOAD_BEATS) : 1,
    localparam int FRAME_W    = LOAD_BEATS * BUS_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        run,
    input  logic [TM_DEPTH*FRAME_W-1:0] task_mem,
    input  logic [NUM_CORES-1:0]        ready,
    output logic [NUM_CORES-1:0]        start,
    output logic [BW-1:0]               insn_beat,
    output logic [BUS_W-1:0]            insn_data,
    output logic                        vga_en,
    input  logic                        vga_end,
    output logic                        busy,
    output logic                        done,
    output logic                        addr_err
);

    localparam int MSK  = 8;
    localparam int FEN  = 8 + NUM_CORES;
    localparam int STP  = 10 + NUM_CORES;
    localparam int LOP  = 11 + NUM_CORES;
    localparam int NXT  = 12 + NUM_CORES;
    localparam int CF_W = NXT + AW;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_GATE, S_LOAD, S_DRAIN, S_DISP, S_VWAIT, S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [7:0]      fcnt_q, fcnt_d;
    logic [CF_W-1:0] cf_q, cf_d;
    logic            err_q, err_d;

    logic [FRAME_W-1:0] frames [TM_DEPTH];
    logic [BUS_W-1:0]   beats  [LOAD_BEATS];
    logic [FRAME_W-1:0] cur_frame;

    for (genvar i = 0; i < TM_DEPTH; i++) begin : g_frm
        assign frames[i] = task_mem[i*FRAME_W +: FRAME_W];
    end

    assign cur_frame = frames[ptr_q];

    for (genvar b = 0; b < LOAD_BEATS; b++) begin : g_beat
        assign beats[b] = cur_frame[b*BUS_W +: BUS_W];
    end

    logic [NUM_CORES-1:0] mask;
    logic [1:0]           fence;
    logic                 stop, loop;
    logic [AW-1:0]        nxt;
    logic                 all_rdy, mask_rdy;

    assign mask     = cf_q[MSK +: NUM_CORES];
    assign fence    = cf_q[FEN +: 2];
    assign stop     = cf_q[STP];
    assign loop     = cf_q[LOP];
    assign nxt      = cf_q[NXT +: AW];
    assign all_rdy  = &ready;
    assign mask_rdy = (ready & mask) == mask;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        fcnt_d  = fcnt_q;
        cf_d    = cf_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (run) begin
                    state_d = S_FETCH;
                    ptr_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: begin
                cf_d    = cur_frame[CF_W-1:0];
                ptr_d   = ptr_q + AW'(1);
                state_d = S_GATE;
            end
            S_GATE: begin
                // Acquire fences need the whole cluster idle, not just the mask
                if (fence[0] ? all_rdy : mask_rdy) begin
                    if (cf_q[7:0] != 8'd0) begin
                        state_d = S_LOAD;
                        beat_d  = '0;
                        fcnt_d  = cf_q[7:0];
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_LOAD: begin
                beat_d = beat_q + BW'(1);
                if (beat_q == BW'(LOAD_BEATS - 1)) begin
                    beat_d = '0;
                    ptr_d  = ptr_q + AW'(1);
                    fcnt_d = fcnt_q - 8'd1;
                    if (fcnt_q == 8'd1)
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!(fence[1] || stop) || all_rdy)
                    state_d = stop ? S_DISP : S_FETCH;
            end
            S_DISP: state_d = S_VWAIT;
            S_VWAIT: begin
                if (vga_end) begin
                    if (loop) begin
                        state_d = S_FETCH;
                        if ({1'b0, nxt} >= (AW+1)'(TM_DEPTH)) begin
                            ptr_d = '0;
                            err_d = 1'b1;
                        end else begin
                            ptr_d = nxt;
                        end
                    end else begin
                        state_d = S_HALT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            beat_q  <= '0;
            fcnt_q  <= '0;
            cf_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            fcnt_q  <= fcnt_d;
            cf_q    <= cf_d;
            err_q   <= err_d;
        end
    end

    assign start     = (state_q == S_LOAD) ? mask : '0;
    assign insn_beat = beat_q;
    assign insn_data = beats[beat_q];
    assign vga_en    = (state_q == S_DISP);
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign done      = (state_q == S_HALT);
    assign addr_err  = err_q;

endmodule

// File: tb/tb_task_dispatcher.sv
// Directed bench for task_dispatcher with a beat scoreboard fed from the
// stimulus steps and drained by an output monitor.
module tb_task_dispatcher;

    localparam int NC = 4;
    localparam int TD = 16;
    localparam int LB = 4;
    localparam int BWD = 16;
    localparam int FW = LB * BWD;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           run = 1'b0;
    logic [TD*FW-1:0] mem = '0;
    logic [NC-1:0]  ready = '1;
    logic [NC-1:0]  start;
    logic [1:0]     insn_beat;
    logic [BWD-1:0] insn_data;
    logic           vga_en;
    logic           vga_end = 1'b0;
    logic           busy, done, addr_err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  st;
        logic [1:0]  bt;
        logic [15:0] d;
    } beat_t;

    beat_t sb[$];
    beat_t mon_it;

    task_dispatcher #(
        .NUM_CORES(NC), .TM_DEPTH(TD), .LOAD_BEATS(LB), .BUS_W(BWD)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .task_mem(mem),
        .ready(ready), .start(start), .insn_beat(insn_beat),
        .insn_data(insn_data), .vga_en(vga_en), .vga_end(vga_end),
        .busy(busy), .done(done), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cf(input int cnt, input logic [3:0] m,
                                       input logic [1:0] f, input bit s,
                                       input bit l, input logic [3:0] nx);
        logic [63:0] v;
        v = '0;
        v[7:0]   = cnt[7:0];
        v[11:8]  = m;
        v[13:12] = f;
        v[14]    = s;
        v[15]    = l;
        v[19:16] = nx;
        return v;
    endfunction

    task automatic set_frame(input int fi, input logic [63:0] v);
        mem[fi*FW +: FW] = v;
    endtask

    task automatic rnd_frame(input int fi);
        set_frame(fi, {$urandom(), $urandom()});
    endtask

    task automatic push_frame(input int fi, input logic [3:0] m, input int nb);
        beat_t it;
        for (int b = 0; b < nb; b++) begin
            it.st = m;
            it.bt = b[1:0];
            it.d  = mem[fi*FW + b*BWD +: BWD];
            sb.push_back(it);
        end
    endtask

    task automatic pulse_run();
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
    endtask

    task automatic wait_vga(input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (vga_en) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic end_pulse();
        @(negedge clk) vga_end = 1'b1;
        @(negedge clk) vga_end = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset && start !== 4'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_start", {60'b0, start}, 64'h0);
            end else begin
                mon_it = sb.pop_front();
                chk("start", {60'b0, start}, {60'b0, mon_it.st});
                chk("beat", {62'b0, insn_beat}, {62'b0, mon_it.bt});
                chk("data", {48'b0, insn_data}, {48'b0, mon_it.d});
            end
        end
    end

    initial begin
        int cyc;

        // reset state
        #2;
        chk("rst_start", {60'b0, start}, 64'h0);
        chk("rst_busy", {63'b0, busy}, 64'h0);
        chk("rst_done", {63'b0, done}, 64'h0);
        chk("rst_vga", {63'b0, vga_en}, 64'h0);
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", {63'b0, busy}, 64'h0);
        chk("idle_beat", {62'b0, insn_beat}, 64'h0);
        chk("idle_err", {63'b0, addr_err}, 64'h0);

        // two frames streamed to mask 0101, then display and halt
        set_frame(0, cf(2, 4'b0101, 2'b00, 1, 0, 4'h0));
        rnd_frame(1);
        rnd_frame(2);
        push_frame(1, 4'b0101, 4);
        push_frame(2, 4'b0101, 4);
        ready = 4'b1111;
        pulse_run();
        chk("t1_busy", {63'b0, busy}, 64'h1);
        wait_vga(40, cyc);
        chk("t1_vga_lat", 64'(cyc), 64'd11);
        chk("t1_sb_empty", 64'(sb.size()), 64'h0);
        @(negedge clk);
        chk("t1_vga_1cyc", {63'b0, vga_en}, 64'h0);
        vga_end = 1'b1;
        @(negedge clk) vga_end = 1'b0;
        chk("t1_done", {63'b0, done}, 64'h1);
        chk("t1_busy_h", {63'b0, busy}, 64'h0);

        // acquire fence holds in GATE until every core is idle
        set_frame(0, cf(1, 4'b0001, 2'b01, 1, 0, 4'h0));
        rnd_frame(1);
        ready = 4'b0001;
        pulse_run();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_hold", {60'b0, start}, 64'h0);
        end
        push_frame(1, 4'b0001, 4);
        ready = 4'b1111;
        @(negedge clk);
        chk("t2_go_start", {60'b0, start}, 64'h1);
        chk("t2_go_beat", {62'b0, insn_beat}, 64'h0);
        wait_vga(20, cyc);
        chk("t2_vga_seen", 64'(cyc > 0), 64'h1);
        end_pulse();
        chk("t2_done", {63'b0, done}, 64'h1);
        chk("t2_sb_empty", 64'(sb.size()), 64'h0);

        // loop back to NEXT=0 after a delayed vga_end
        set_frame(0, cf(1, 4'b1111, 2'b00, 1, 1, 4'h0));
        rnd_frame(1);
        push_frame(1, 4'b1111, 4);
        pulse_run();
        wait_vga(20, cyc);
        chk("t3_vga_seen", 64'(cyc > 0), 64'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_wait_busy", {63'b0, busy}, 64'h1);
            chk("t3_wait_vga", {63'b0, vga_en}, 64'h0);
        end
        end_pulse();
        chk("t3_loop_busy", {63'b0, busy}, 64'h1);
        set_frame(0, cf(1, 4'b1111, 2'b00, 1, 0, 4'h0));
        push_frame(1, 4'b1111, 4);
        wait_vga(20, cyc);
        chk("t3_vga2_seen", 64'(cyc > 0), 64'h1);
        end_pulse();
        chk("t3_done", {63'b0, done}, 64'h1);
        chk("t3_sb_empty", 64'(sb.size()), 64'h0);

        // jump to frame 15, instruction frames wrap to 0 and 1
        set_frame(0, cf(0, 4'b0000, 2'b00, 1, 1, 4'hF));
        rnd_frame(1);
        set_frame(2, cf(0, 4'b0000, 2'b00, 1, 0, 4'h0));
        set_frame(15, cf(2, 4'b0011, 2'b00, 0, 0, 4'h0));
        pulse_run();
        wait_vga(20, cyc);
        chk("t4_vga1_lat", 64'(cyc), 64'd3);
        push_frame(0, 4'b0011, 4);
        push_frame(1, 4'b0011, 4);
        end_pulse();
        chk("t4_loop_busy", {63'b0, busy}, 64'h1);
        wait_vga(40, cyc);
        chk("t4_vga2_seen", 64'(cyc > 0), 64'h1);
        end_pulse();
        chk("t4_done", {63'b0, done}, 64'h1);
        chk("t4_addr_err", {63'b0, addr_err}, 64'h0);
        chk("t4_sb_empty", 64'(sb.size()), 64'h0);

        // reset in the middle of a frame
        set_frame(0, cf(2, 4'b1010, 2'b00, 1, 0, 4'h0));
        rnd_frame(1);
        rnd_frame(2);
        push_frame(1, 4'b1010, 3);
        pulse_run();
        cyc = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (start !== 4'b0 && insn_beat == 2'd2) begin
                cyc = i;
                break;
            end
        end
        chk("t5_beat2_seen", 64'(cyc > 0), 64'h1);
        reset = 1'b1;
        #1;
        chk("t5_rst_start", {60'b0, start}, 64'h0);
        chk("t5_rst_busy", {63'b0, busy}, 64'h0);
        chk("t5_rst_done", {63'b0, done}, 64'h0);
        chk("t5_rst_beat", {62'b0, insn_beat}, 64'h0);
        @(negedge clk) reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_stay_idle", {63'b0, busy}, 64'h0);
        chk("t5_sb_empty", 64'(sb.size()), 64'h0);

        // release fence waits in DRAIN for all cores, then restarts at frame 2
        set_frame(0, cf(1, 4'b0100, 2'b10, 0, 0, 4'h0));
        rnd_frame(1);
        set_frame(2, cf(0, 4'b0000, 2'b00, 1, 0, 4'h0));
        push_frame(1, 4'b0100, 4);
        ready = 4'b0100;
        pulse_run();
        repeat (10) @(negedge clk);
        chk("t6_drain_busy", {63'b0, busy}, 64'h1);
        chk("t6_drain_start", {60'b0, start}, 64'h0);
        chk("t6_drain_vga", {63'b0, vga_en}, 64'h0);
        chk("t6_sb_empty", 64'(sb.size()), 64'h0);
        ready = 4'b1111;
        wait_vga(20, cyc);
        chk("t6_vga_lat", 64'(cyc), 64'd4);
        end_pulse();
        chk("t6_done", {63'b0, done}, 64'h1);
        chk("t6_busy", {63'b0, busy}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
